// File: rtl/sequence_checker.sv
// sequence_checker: captures a short sequence of generator values, then
// compares the player's guesses against it in order and keeps a score.
module sequence_checker #(
    parameter int SEQ_LEN = 4,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auth_bit,
    input  logic [WIDTH-1:0] random_num,
    input  logic             enable,
    input  logic [WIDTH-1:0] guess,
    input  logic             guess_valid,
    input  logic             clear,
    output logic             loading,
    output logic             checking,
    output logic             pass,
    output logic             fail,
    output logic [3:0]       score,
    output logic [2:0]       state
);

    // Pointers are one bit wider than strictly needed so they can reach SEQ_LEN.
    localparam int PTR_W = $clog2(SEQ_LEN + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(SEQ_LEN - 1);
    localparam logic [3:0]       SCORE_MAX = 4'(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t           cur_state, nxt_state;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [3:0]       score_q, score_nxt;
    logic             buf_we;

    // Sequence storage; contents are not reset, a new round always reloads it.
    logic [WIDTH-1:0] seq_buf [0:(1<<PTR_W)-1];

    // Score increment that sticks at SEQ_LEN instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= SCORE_MAX) ? v : v + 4'd1;
    endfunction

    // Control registers: state, pointers and score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            score_q   <= '0;
        end else begin
            cur_state <= nxt_state;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            score_q   <= score_nxt;
        end
    end

    // Next-state logic; losing authentication or a clear beats any data strobe.
    always_comb begin
        nxt_state  = cur_state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        score_nxt  = score_q;
        buf_we     = 1'b0;
        if (cur_state != S_IDLE && (!auth_bit || clear)) begin
            nxt_state  = S_IDLE;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            score_nxt  = '0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (auth_bit) begin
                        nxt_state  = S_LOAD;
                        wr_ptr_nxt = '0;
                        rd_ptr_nxt = '0;
                        score_nxt  = '0;
                    end
                end
                S_LOAD: begin
                    if (enable) begin
                        buf_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        if (wr_ptr == LAST_IDX) begin
                            nxt_state  = S_CHECK;
                            rd_ptr_nxt = '0;
                        end
                    end
                end
                S_CHECK: begin
                    if (guess_valid) begin
                        if (guess == seq_buf[rd_ptr]) begin
                            score_nxt  = sat_inc(score_q);
                            rd_ptr_nxt = rd_ptr + PTR_W'(1);
                            if (rd_ptr == LAST_IDX) begin
                                nxt_state = S_PASS;
                            end
                        end else begin
                            nxt_state = S_FAIL;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer write port, active only for an accepted capture in LOAD.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            seq_buf[wr_ptr] <= random_num;
        end
    end

    assign loading  = (cur_state == S_LOAD);
    assign checking = (cur_state == S_CHECK);
    assign pass     = (cur_state == S_PASS);
    assign fail     = (cur_state == S_FAIL);
    assign score    = score_q;
    assign state    = cur_state;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed and randomized bench for sequence_checker against a queue-based model.
module tb_sequence_checker;

    localparam int SEQ_LEN = 4;
    localparam int WIDTH   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             auth_bit;
    logic [WIDTH-1:0] random_num;
    logic             enable;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             clear;
    logic             loading;
    logic             checking;
    logic             pass;
    logic             fail;
    logic [3:0]       score;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase uses the debug encoding (0 idle .. 4 fail).
    int               m_phase;
    int               m_score;
    int               m_rd;
    logic [WIDTH-1:0] m_seq[$];

    sequence_checker #(.SEQ_LEN(SEQ_LEN), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .auth_bit(auth_bit), .random_num(random_num),
        .enable(enable), .guess(guess), .guess_valid(guess_valid), .clear(clear),
        .loading(loading), .checking(checking), .pass(pass), .fail(fail),
        .score(score), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",    8'(state),    8'(m_phase));
        chk("score",    8'(score),    8'(m_score));
        chk("loading",  8'(loading),  8'(m_phase == 1));
        chk("checking", 8'(checking), 8'(m_phase == 2));
        chk("pass",     8'(pass),     8'(m_phase == 3));
        chk("fail",     8'(fail),     8'(m_phase == 4));
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_score = 0;
        m_rd    = 0;
        m_seq.delete();
    endtask

    task automatic model_step(input logic a, input logic e, input logic [WIDTH-1:0] rn,
                              input logic gv, input logic [WIDTH-1:0] g, input logic c);
        if (m_phase != 0 && (!a || c)) begin
            model_clear();
        end else begin
            case (m_phase)
                0: if (a) begin
                    model_clear();
                    m_phase = 1;
                end
                1: if (e) begin
                    m_seq.push_back(rn);
                    if (m_seq.size() == SEQ_LEN) m_phase = 2;
                end
                2: if (gv) begin
                    if (g == m_seq[m_rd]) begin
                        m_score = (m_score + 1 > SEQ_LEN) ? SEQ_LEN : m_score + 1;
                        m_rd++;
                        if (m_rd == SEQ_LEN) m_phase = 3;
                    end else begin
                        m_phase = 4;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit after the rising edge.
    task automatic cyc(input logic a, input logic e, input logic [WIDTH-1:0] rn,
                       input logic gv, input logic [WIDTH-1:0] g, input logic c);
        auth_bit    = a;
        enable      = e;
        random_num  = rn;
        guess_valid = gv;
        guess       = g;
        clear       = c;
        @(posedge clk);
        model_step(a, e, rn, gv, g, c);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic ld(input logic [WIDTH-1:0] v);
        cyc(1'b1, 1'b1, v, 1'b0, '0, 1'b0);
    endtask

    task automatic gs(input logic [WIDTH-1:0] v);
        cyc(1'b1, 1'b0, '0, 1'b1, v, 1'b0);
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic clr_cyc();
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic             ra, re, rgv, rc;
        logic [WIDTH-1:0] rrn, rg;

        rst = 1'b1;
        auth_bit = 1'b0; enable = 1'b0; guess_valid = 1'b0; clear = 1'b0;
        random_num = '0; guess = '0;
        model_clear();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Round 1: load 3,9,0,15 and guess all correctly.
        idle_cyc();
        ld(4'd3); ld(4'd9); ld(4'd0); ld(4'd15);
        chk("check_after_load", 8'(checking), 8'd1);
        gs(4'd3); gs(4'd9); gs(4'd0); gs(4'd15);
        chk("pass_after_last", 8'(pass), 8'd1);
        idle_cyc(); idle_cyc();
        chk("pass_hold", 8'(pass), 8'd1);
        chk("pass_score", 8'(score), 8'd4);
        clr_cyc();
        chk("clear_score", 8'(score), 8'd0);

        // Round 2: wrong second guess, later guesses are ignored in FAIL.
        idle_cyc();
        ld(4'd3); ld(4'd9); ld(4'd0); ld(4'd15);
        gs(4'd3); gs(4'd8);
        chk("fail_flag", 8'(fail), 8'd1);
        gs(4'd9);
        chk("fail_score_hold", 8'(score), 8'd1);
        clr_cyc();

        // Round 3: stray guess in LOAD and stray capture in CHECK leave the buffer intact.
        idle_cyc();
        ld(4'd3);
        cyc(1'b1, 1'b0, '0, 1'b1, 4'd5, 1'b0);
        ld(4'd9); ld(4'd0);
        cyc(1'b1, 1'b1, 4'd15, 1'b1, 4'd5, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 1'b0, '0, 1'b0);
        gs(4'd3); gs(4'd9); gs(4'd0); gs(4'd15);
        chk("pass_after_stray", 8'(pass), 8'd1);
        clr_cyc();

        // Round 4: drop auth mid-load together with an enable, then reload.
        idle_cyc();
        ld(4'd5); ld(4'd6);
        cyc(1'b0, 1'b1, 4'd7, 1'b0, '0, 1'b0);
        chk("auth_drop_idle", 8'(state), 8'd0);
        idle_cyc();
        ld(4'd1); ld(4'd2); ld(4'd3); ld(4'd4);
        gs(4'd1); gs(4'd2); gs(4'd3); gs(4'd4);
        chk("pass_after_reload", 8'(pass), 8'd1);
        clr_cyc();

        // Round 5: asynchronous reset in CHECK with score 2.
        idle_cyc();
        ld(4'd3); ld(4'd9); ld(4'd0); ld(4'd15);
        gs(4'd3); gs(4'd9);
        chk("pre_rst_score", 8'(score), 8'd2);
        #2;
        rst = 1'b1;
        auth_bit = 1'b0; enable = 1'b0; guess_valid = 1'b0; clear = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("async_rst_state", 8'(state), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            ra  = ($urandom_range(0, 59) != 0);
            rc  = (m_phase >= 3) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            re  = 1'($urandom_range(0, 1));
            rgv = 1'($urandom_range(0, 1));
            rrn = WIDTH'($urandom);
            if (m_phase == 2 && m_rd < m_seq.size() && $urandom_range(0, 5) != 0)
                rg = m_seq[m_rd];
            else
                rg = WIDTH'($urandom);
            cyc(ra, re, rrn, rgv, rg, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
